// File: rtl/pjw_driver.sv
// pjw_driver: byte-stream front end for the PJW hash core.
// Packs a byte-serial message big-endian into 32-bit words, issues the
// word-count/word sequence to the core, captures its hash and returns it on a
// valid/ready result port. Oversized messages are drained and flagged.
// Optional build macro PJW_DRV_TIMEOUT_EN adds a watchdog on the core response.
module pjw_driver #(
    parameter int unsigned MAX_WORDS      = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        in_ready,
    output logic        core_valid,
    output logic [31:0] core_data,
    input  logic        core_ready,
    input  logic [31:0] core_hash,
    output logic        res_valid,
    output logic [31:0] res_hash,
    output logic        res_err,
    input  logic        res_ready
);

    localparam int unsigned WC_W = 3;
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WORDS);

    // Reject configurations the core's word store cannot hold.
    if (MAX_WORDS < 1 || MAX_WORDS > 6 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("pjw_driver: MAX_WORDS must be 1..6 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_FILL,
        S_SEND_LEN,
        S_SEND_DATA,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t            state, state_next;
    logic [31:0]       word_buf [MAX_WORDS];
    logic [31:0]       buf_next [MAX_WORDS];
    logic [WC_W-1:0]   wcnt, wcnt_next;
    logic [1:0]        bcnt, bcnt_next;
    logic [WC_W-1:0]   nwords, nwords_next;
    logic [WC_W-1:0]   widx, widx_next;
    logic              ovf, ovf_next;
    logic              in_ready_next;
    logic              core_valid_next;
    logic [31:0]       core_data_next;
    logic              res_valid_next;
    logic [31:0]       res_hash_next;
    logic              res_err_next;
    logic              byte_acc;

`ifdef PJW_DRV_TIMEOUT_EN
    localparam int unsigned TC_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYCLES - 1);
    logic [TC_W-1:0]   tcnt, tcnt_next;
`endif

    assign byte_acc = in_valid & in_ready;

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FILL;
            for (int i = 0; i < int'(MAX_WORDS); i++) begin
                word_buf[i] <= '0;
            end
            wcnt       <= '0;
            bcnt       <= '0;
            nwords     <= '0;
            widx       <= '0;
            ovf        <= 1'b0;
            in_ready   <= 1'b0;
            core_valid <= 1'b0;
            core_data  <= '0;
            res_valid  <= 1'b0;
            res_hash   <= '0;
            res_err    <= 1'b0;
`ifdef PJW_DRV_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            state      <= state_next;
            word_buf   <= buf_next;
            wcnt       <= wcnt_next;
            bcnt       <= bcnt_next;
            nwords     <= nwords_next;
            widx       <= widx_next;
            ovf        <= ovf_next;
            in_ready   <= in_ready_next;
            core_valid <= core_valid_next;
            core_data  <= core_data_next;
            res_valid  <= res_valid_next;
            res_hash   <= res_hash_next;
            res_err    <= res_err_next;
`ifdef PJW_DRV_TIMEOUT_EN
            tcnt       <= tcnt_next;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next      = state;
        buf_next        = word_buf;
        wcnt_next       = wcnt;
        bcnt_next       = bcnt;
        nwords_next     = nwords;
        widx_next       = widx;
        ovf_next        = ovf;
        core_valid_next = 1'b0;
        core_data_next  = '0;
        res_valid_next  = res_valid;
        res_hash_next   = res_hash;
        res_err_next    = res_err;
`ifdef PJW_DRV_TIMEOUT_EN
        tcnt_next       = '0;
`endif

        case (state)
            S_FILL: begin
                if (byte_acc) begin
                    if (wcnt == WC_MAX) begin
                        // Byte beyond capacity: flag and discard the rest.
                        ovf_next = 1'b1;
                        if (in_last) begin
                            state_next     = S_RESP;
                            res_valid_next = 1'b1;
                            res_err_next   = 1'b1;
                            res_hash_next  = '0;
                        end else begin
                            state_next = S_DRAIN;
                        end
                    end else begin
                        buf_next[wcnt][{~bcnt, 3'b000} +: 8] = in_byte;
                        bcnt_next = bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            wcnt_next = wcnt + WC_W'(1);
                        end
                        if (in_last) begin
                            // The byte just written lives in word wcnt, so the
                            // message spans wcnt+1 words whether or not it is full.
                            nwords_next = wcnt + WC_W'(1);
                            state_next  = S_SEND_LEN;
                            if (core_ready) begin
                                core_valid_next = 1'b1;
                                core_data_next  = {29'b0, wcnt + WC_W'(1)};
                            end
                        end
                    end
                end
            end

            S_SEND_LEN: begin
                if (core_valid) begin
                    // Length word is on the bus this cycle; follow with word 0.
                    state_next      = S_SEND_DATA;
                    core_valid_next = 1'b1;
                    core_data_next  = word_buf[0];
                    widx_next       = WC_W'(1);
                end else if (core_ready) begin
                    core_valid_next = 1'b1;
                    core_data_next  = {29'b0, nwords};
                end
            end

            S_SEND_DATA: begin
                if (widx == nwords) begin
                    state_next = S_WAIT;
                end else begin
                    core_valid_next = 1'b1;
                    core_data_next  = word_buf[widx];
                    widx_next       = widx + WC_W'(1);
                end
            end

            S_WAIT: begin
                if (core_ready) begin
                    state_next     = S_RESP;
                    res_valid_next = 1'b1;
                    res_hash_next  = core_hash;
                    res_err_next   = 1'b0;
                end
`ifdef PJW_DRV_TIMEOUT_EN
                else if (tcnt == TC_LAST) begin
                    state_next     = S_RESP;
                    res_valid_next = 1'b1;
                    res_hash_next  = '0;
                    res_err_next   = 1'b1;
                end else begin
                    tcnt_next = tcnt + TC_W'(1);
                end
`endif
            end

            S_RESP: begin
                if (res_ready) begin
                    state_next     = S_FILL;
                    res_valid_next = 1'b0;
                    for (int i = 0; i < int'(MAX_WORDS); i++) begin
                        buf_next[i] = '0;
                    end
                    wcnt_next = '0;
                    bcnt_next = '0;
                    ovf_next  = 1'b0;
                end
            end

            S_DRAIN: begin
                if (byte_acc && in_last) begin
                    state_next     = S_RESP;
                    res_valid_next = 1'b1;
                    res_err_next   = ovf;
                    res_hash_next  = '0;
                end
            end

            default: begin
                state_next = S_FILL;
            end
        endcase

        // Only one message in flight: accept bytes only while filling or draining.
        in_ready_next = (state_next == S_FILL) || (state_next == S_DRAIN);
    end

endmodule

// File: tb/tb_pjw_driver.sv
// Testbench for pjw_driver: directed messages against a byte-level PJW core
// model and a message-level scoreboard of expected core words and results.
module tb_pjw_driver;

`ifdef PJW_DRV_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        in_ready;
    logic        core_valid;
    logic [31:0] core_data;
    logic        core_ready = 1'b1;
    logic [31:0] core_hash = '0;
    logic        res_valid;
    logic [31:0] res_hash;
    logic        res_err;
    logic        res_ready;

    always #5 clk = ~clk;

    pjw_driver #(.MAX_WORDS(6), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last), .in_ready(in_ready),
        .core_valid(core_valid), .core_data(core_data),
        .core_ready(core_ready), .core_hash(core_hash),
        .res_valid(res_valid), .res_hash(res_hash), .res_err(res_err),
        .res_ready(res_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_core [$];
    logic [32:0] exp_res  [$];
    logic [31:0] cap_words [$];
    logic [31:0] last_hash;
    logic        last_err;
    int          n_results = 0;
    logic        core_hold_low = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // PJW step over the four big-endian bytes of one word.
    function automatic logic [31:0] pjw_word(input logic [31:0] h_in, input logic [31:0] w);
        logic [31:0] h;
        logic [31:0] g;
        h = h_in;
        for (int k = 0; k < 4; k++) begin
            h = (h << 4) + {24'b0, w[31-8*k -: 8]};
            g = h & 32'hF000_0000;
            if (g != 0) begin
                h = h ^ (g >> 24);
                h = h & ~g;
            end
        end
        return h;
    endfunction

    // Hash core model: length word on Valid&Ready, n words back-to-back, 5 cycles/word.
    int          cm_st = 0;
    int          cm_n;
    int          cm_rx;
    int          cm_busy;
    logic [31:0] cm_h;
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                core_ready <= 1'b1;
                core_hash  <= '0;
                cm_st = 0;
            end else begin
                case (cm_st)
                    0: if (core_valid && core_ready) begin
                        cm_n  = int'(core_data[2:0]);
                        cm_rx = 0;
                        cm_h  = '0;
                        core_ready <= 1'b0;
                        cm_st = 1;
                    end
                    1: if (core_valid) begin
                        cm_h  = pjw_word(cm_h, core_data);
                        cm_rx = cm_rx + 1;
                        if (cm_rx == cm_n) begin
                            cm_busy = 5 * cm_n;
                            cm_st = 2;
                        end
                    end
                    default: if (!core_hold_low) begin
                        cm_busy = cm_busy - 1;
                        if (cm_busy <= 0) begin
                            core_hash  <= cm_h;
                            core_ready <= 1'b1;
                            cm_st = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Compare process: core bus and result port against the scoreboard, every cycle.
    int          burst_left = 0;
    logic        res_pending = 1'b0;
    logic [32:0] cur_res;
    initial begin
        logic [31:0] e;
        logic [32:0] er;
        forever begin
            @(negedge clk);
            if (rst) begin
                burst_left  = 0;
                res_pending = 1'b0;
            end else begin
                if (core_valid) begin
                    cap_words.push_back(core_data);
                    if (exp_core.size() == 0) begin
                        check("core_valid_unexpected", 64'(core_valid), 64'(0));
                    end else begin
                        e = exp_core.pop_front();
                        check("core_data", 64'(core_data), 64'(e));
                        if (burst_left == 0) burst_left = int'(e[2:0]);
                        else burst_left = burst_left - 1;
                    end
                end else if (burst_left > 0) begin
                    check("core_valid_gap", 64'(core_valid), 64'(1));
                    burst_left = 0;
                end

                if (res_valid) begin
                    check("in_ready_during_resp", 64'(in_ready), 64'(0));
                    if (!res_pending) begin
                        if (exp_res.size() == 0) begin
                            check("res_valid_unexpected", 64'(res_valid), 64'(0));
                        end else begin
                            er = exp_res.pop_front();
                            check("res_hash", 64'(res_hash), 64'(er[31:0]));
                            check("res_err", 64'(res_err), 64'(er[32]));
                        end
                        cur_res     = {res_err, res_hash};
                        last_hash   = res_hash;
                        last_err    = res_err;
                        n_results   = n_results + 1;
                        res_pending = 1'b1;
                    end else begin
                        check("res_stable", 64'({res_err, res_hash}), 64'(cur_res));
                    end
                    if (res_ready) res_pending = 1'b0;
                end
            end
        end
    end

    // Scoreboard entries for one message, from its bytes.
    task automatic expect_msg(input logic [7:0] m [$], input logic timeout_err);
        int n;
        logic [31:0] w;
        logic [31:0] h;
        if (m.size() > 24) begin
            exp_res.push_back({1'b1, 32'h0});
        end else begin
            n = (m.size() + 3) / 4;
            exp_core.push_back(32'(n));
            h = '0;
            for (int i = 0; i < n; i++) begin
                w = '0;
                for (int k = 0; k < 4; k++) begin
                    if (4*i + k < m.size()) w[31-8*k -: 8] = m[4*i + k];
                end
                exp_core.push_back(w);
                h = pjw_word(h, w);
            end
            if (timeout_err) exp_res.push_back({1'b1, 32'h0});
            else exp_res.push_back({1'b0, h});
        end
    endtask

    task automatic send_bytes(input logic [7:0] m [$]);
        logic acc;
        for (int i = 0; i < m.size(); i++) begin
            in_valid = 1'b1;
            in_byte  = m[i];
            in_last  = (i == m.size() - 1);
            acc = 1'b0;
            for (int t = 0; t < 2000 && !acc; t++) begin
                @(negedge clk);
                if (in_ready) acc = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!acc) check("in_ready_timeout", 64'(acc), 64'(1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input int n0);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 5000 && !done; t++) begin
            @(posedge clk);
            #2;
            if (n_results > n0 && !res_valid) done = 1'b1;
        end
        if (!done) check("result_timeout", 64'(done), 64'(1));
    endtask

    task automatic run_msg(input logic [7:0] m [$]);
        int n0;
        n0 = n_results;
        cap_words.delete();
        expect_msg(m, 1'b0);
        send_bytes(m);
        wait_result(n0);
    endtask

    task automatic wait_core_valid(input logic level);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 2000 && !seen; t++) begin
            @(negedge clk);
            if (core_valid == level) seen = 1'b1;
        end
        if (!seen) check("core_valid_wait_timeout", 64'(seen), 64'(1));
    endtask

    initial begin
        logic [7:0] m_a [$];
        logic [7:0] m_abcd [$];
        logic [7:0] m_24 [$];
        logic [7:0] m_26 [$];
        logic [7:0] m_5 [$];
        int n0;
        logic seen;

        m_a    = {8'h41};
        m_abcd = {8'h41, 8'h42, 8'h43, 8'h44};
        m_5    = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        for (int i = 0; i < 24; i++) m_24.push_back(8'(i));
        for (int i = 0; i < 26; i++) m_26.push_back(8'(8'hA0 + i));

        rst = 1'b1; in_valid = 1'b0; in_byte = '0; in_last = 1'b0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready",   64'(in_ready),   64'(0));
        check("reset_core_valid", 64'(core_valid), 64'(0));
        check("reset_core_data",  64'(core_data),  64'(0));
        check("reset_res_valid",  64'(res_valid),  64'(0));
        check("reset_res_hash",   64'(res_hash),   64'(0));
        check("reset_res_err",    64'(res_err),    64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Single byte, partial word padded with zeros.
        run_msg(m_a);
        check("a_words", 64'(cap_words.size()), 64'(2));
        if (cap_words.size() >= 2) begin
            check("a_len_word",  64'(cap_words[0]), 64'(32'h0000_0001));
            check("a_data_word", 64'(cap_words[1]), 64'(32'h4100_0000));
        end
        check("a_hash", 64'(last_hash), 64'(32'h0004_1000));
        check("a_err",  64'(last_err),  64'(0));

        run_msg(m_abcd);
        if (cap_words.size() >= 2) check("abcd_data_word", 64'(cap_words[1]), 64'(32'h4142_4344));
        check("abcd_hash", 64'(last_hash), 64'(32'h0004_5674));

        // Full capacity: 24 bytes is legal.
        run_msg(m_24);
        check("full_words", 64'(cap_words.size()), 64'(7));
        if (cap_words.size() >= 7) begin
            check("full_len_word",   64'(cap_words[0]), 64'(6));
            check("full_first_word", 64'(cap_words[1]), 64'(32'h0001_0203));
            check("full_last_word",  64'(cap_words[6]), 64'(32'h1415_1617));
        end

        // Overflow: drained, core untouched, then normal operation resumes.
        run_msg(m_26);
        check("ovf_core_words", 64'(cap_words.size()), 64'(0));
        check("ovf_err",  64'(last_err),  64'(1));
        check("ovf_hash", 64'(last_hash), 64'(0));
        run_msg(m_abcd);
        check("after_ovf_hash", 64'(last_hash), 64'(32'h0004_5674));

        // Result held under backpressure.
        res_ready = 1'b0;
        n0 = n_results;
        cap_words.delete();
        expect_msg(m_5, 1'b0);
        send_bytes(m_5);
        seen = 1'b0;
        for (int t = 0; t < 2000 && !seen; t++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("hold_res_seen", 64'(seen), 64'(1));
        repeat (10) @(negedge clk);
        check("hold_res_valid", 64'(res_valid), 64'(1));
        check("hold_in_ready",  64'(in_ready),  64'(0));
        @(posedge clk); #1 res_ready = 1'b1;
        wait_result(n0);

        // Reset in the middle of the data burst.
        cap_words.delete();
        expect_msg(m_24, 1'b0);
        send_bytes(m_24);
        wait_core_valid(1'b1);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_core_valid", 64'(core_valid), 64'(0));
        check("midrst_res_valid",  64'(res_valid),  64'(0));
        check("midrst_in_ready",   64'(in_ready),   64'(0));
        exp_core.delete();
        exp_res.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); @(negedge clk);
        check("midrst_fill_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        run_msg(m_abcd);
        check("after_rst_hash", 64'(last_hash), 64'(32'h0004_5674));

`ifdef PJW_DRV_TIMEOUT_EN
        // Core never answers: watchdog reports an error 16 cycles into WAIT.
        begin
            int idx;
            core_hold_low = 1'b1;
            n0 = n_results;
            cap_words.delete();
            expect_msg(m_a, 1'b1);
            send_bytes(m_a);
            wait_core_valid(1'b1);
            wait_core_valid(1'b0);
            idx = 0;
            seen = res_valid;
            for (int t = 0; t < 100 && !seen; t++) begin
                @(negedge clk);
                idx++;
                if (res_valid) seen = 1'b1;
            end
            check("timeout_seen",  64'(seen), 64'(1));
            check("timeout_cycle", 64'(idx),  64'(16));
            wait_result(n0);
            check("timeout_err",  64'(last_err),  64'(1));
            check("timeout_hash", 64'(last_hash), 64'(0));
            core_hold_low = 1'b0;
        end
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/pjw_driver.md
# pjw_driver

Initiator-side front end for the PJW hash core. Accepts a byte-serial message from an upstream valid/ready stream and packs it big-endian into 32-bit words. Issues the word-count/word sequence to the core on its `Valid`/`DataIn`/`Ready` interface, captures `DataOut` when the core finishes, and returns the hash on a valid/ready result port. Sits between the byte-stream fabric and the hash core; the core needs no changes.

## Interface
- `MAX_WORDS`, default 6: message capacity in words (24 bytes). Fixed by the core's word store; legal range 1–6.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in WAIT, used only when `PJW_DRV_TIMEOUT_EN` is defined.
- `clk`  in  1  clock, all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream byte valid.
- `in_byte`  in  8  message byte.
- `in_last`  in  1  last byte of the message, qualified by `in_valid`.
- `in_ready`  out  1  byte accepted when `in_valid & in_ready`.
- `core_valid`  out  1  drives the core's `Valid`.
- `core_data`  out  32  drives the core's `DataIn`.
- `core_ready`  in  1  the core's `Ready`, which is registered.
- `core_hash`  in  32  the core's `DataOut`.
- `res_valid`  out  1  result available.
- `res_hash`  out  32  hash result; 0 when `res_err` is set.
- `res_err`  out  1  1 = message overflowed (or timed out, see Configuration).
- `res_ready`  in  1  result consumed when `res_valid & res_ready`.

## Operation
- States: FILL, SEND_LEN, SEND_DATA, WAIT, RESP, DRAIN.
- **FILL**
  - `in_ready`=1.
  - Each accepted byte goes to `buf[wcnt]` at byte lane `3-bcnt`: first byte in [31:24], fourth in [7:0].
  - `bcnt` (2 bits) wraps 3→0 and increments `wcnt`.
  - An accepted byte arriving when `wcnt==MAX_WORDS` (25th byte) sets `ovf`. If that byte carries `in_last`, go to RESP with err; otherwise go to DRAIN.
  - Accepted `in_last` without overflow:
    - Set `nwords = wcnt + (bcnt!=0 after the write ? 1 : 0)`.
    - Unwritten low lanes of a partial final word are 0.
    - Go to SEND_LEN.
- **SEND_LEN**
  - `in_ready`=0.
  - Stay while `core_ready`=0.
  - When `core_ready`=1, assert `core_valid`=1 with `core_data`={29'b0, `nwords`} for exactly one cycle, then go to SEND_DATA with `widx`=0.
- **SEND_DATA**
  - `core_valid`=1 and `core_data`=`buf[widx]` every cycle, `widx`++.
  - No per-word handshake: the core accepts every `Valid` cycle, and `core_ready` is ignored here.
  - After `buf[nwords-1]` is sent, go to WAIT.
  - Words are sent back-to-back with no gaps, in message order.
- **WAIT**
  - `core_valid`=0.
  - On the first cycle `core_ready`=1, capture `core_hash` into `res_hash`, set `res_err`=0, go to RESP.
  - Entering WAIT, `core_ready` is guaranteed 0, because it dropped one cycle after the length word.
- **DRAIN**
  - `in_ready`=1; discard bytes until an accepted `in_last`, then go to RESP with `res_err`=1 and `res_hash`=0.
  - The core is never touched.
- **RESP**
  - `res_valid`=1; `res_hash`/`res_err` stay stable until `res_ready`.
  - On handshake, clear `buf`, `wcnt`, `bcnt`, `ovf`, and return to FILL.
- `in_ready` is 0 in SEND_LEN, SEND_DATA, WAIT and RESP. Backpressure is whole-message: one message in flight.

## Timing
- Reset values: `in_ready`=0 during reset and 1 from the first cycle after. `core_valid`=0, `core_data`=0, `res_valid`=0, `res_hash`=0, `res_err`=0, state=FILL, `buf` cleared.
- Fill: 1 byte/cycle at full rate.
- Core issue: `core_valid` is high for `1+nwords` consecutive cycles, starting the cycle after `in_last` is accepted if `core_ready`=1.
- Result: `res_valid` rises the cycle after `core_ready` returns to 1 in WAIT.
- End-to-end core latency is `1+nwords` issue cycles plus 5 core cycles per word.
- `res_valid` and `res_ready` in the same cycle (`res_ready` already high): result is consumed; FILL is entered next cycle.
- Reset mid-operation:
  - Aborts immediately; outputs go to their reset values.
  - A partially sent message leaves the core inconsistent. The system must reset the core together with this block; they share `rst`.
- `in_last` on the 24th byte exactly is legal (`nwords`=6). Only the 25th byte overflows.

## Configuration
- `PJW_DRV_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT.
  - If `core_ready` stays 0 for `TIMEOUT_CYCLES` cycles, go to RESP with `res_err`=1 and `res_hash`=0.
  - The counter clears on leaving WAIT.
- Not defined: no counter; WAIT waits indefinitely.

## Test plan
- "A" (0x41, `in_last`) → `core_data` sequence 0x00000001, 0x41000000; `res_hash`=0x00041000, `res_err`=0.
- "ABCD" → 0x00000001, 0x41424344; `res_hash`=0x00045674.
- 24 bytes 0x00..0x17 → length word 6 then 0x00010203…0x14151617 back-to-back; `res_hash` matches the bit-exact PJW model over all 24 bytes.
- 26 bytes, `in_last` on the 26th → `core_valid` never asserted; `res_err`=1, `res_hash`=0; the next message "ABCD" hashes to 0x00045674.
- Hold `res_ready`=0 for 10 cycles → `res_valid`/`res_hash` stable and `in_ready`=0 throughout. Separately, assert `rst` during SEND_DATA → next cycle `core_valid`=0, `res_valid`=0, FILL.
- With `PJW_DRV_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: tie `core_ready` low after the length word → `res_valid` with `res_err`=1 exactly 16 cycles after entering WAIT.
